// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and fixed constants.
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a combinational head, a flush input and an occupancy count.
module fetch_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush discards everything held
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage write; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order memory
// requests, buffers responses and hands {instr, pc} to decode.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);

   fetch_state_t     state;
   logic [31:0]      pc_q;
   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] drop;
   logic [CNT_W:0]   credit_sum;

   logic             req_fire;
   logic             rsp_keep;
   logic             id_fire;

   logic [63:0]      fifo_head;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;

   logic [31:0]      tag_head;
   logic [CNT_W-1:0] tag_count;
   logic             tag_full;
   logic             tag_empty;

   // Buffered entries plus in-flight requests bound the outstanding total
   assign credit_sum     = {1'b0, fifo_count} + {1'b0, inflight};
   assign imem_req_valid = (state == S_RUN) & ~redirect_valid
                         & (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;

   // Responses owed to a redirected-away stream are counted down in drop
   assign rsp_keep = imem_rsp_valid & ~redirect_valid & (drop == '0);

   assign id_valid = ~fifo_empty & ~redirect_valid;
   assign id_fire  = id_valid & id_ready;
   assign id_instr = id_valid ? fifo_head[31:0]  : NOP_INSTR;
   assign id_pc    = id_valid ? fifo_head[63:32] : '0;

   // Request PCs, matched in order to kept responses
   fetch_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (req_fire),
      .push_data (pc_q),
      .pop       (rsp_keep),
      .head      (tag_head),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   // Fetched {pc, instr} pairs awaiting decode
   fetch_fifo #(
      .WIDTH (64),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_data_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (rsp_keep),
      .push_data ({tag_head, imem_rsp_data}),
      .pop       (id_fire),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Boot FSM, PC, in-flight and drop counters; redirect takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_BOOT;
         pc_q     <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         case (state)
            S_BOOT:  state <= S_RUN;
            S_RUN:   state <= S_RUN;
            default: state <= S_BOOT;
         endcase
         if (redirect_valid) begin
            // No request can fire here; a same-cycle response is discarded
            pc_q     <= {redirect_pc[31:2], 2'b00};
            inflight <= inflight - CNT_W'(imem_rsp_valid);
            drop     <= inflight - CNT_W'(imem_rsp_valid);
         end else begin
            if (req_fire) pc_q <= pc_q + 32'd4;
            inflight <= inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
            if (imem_rsp_valid && (drop != '0)) drop <= drop - CNT_W'(1);
         end
      end
   end

   // Credit-scheme invariants
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(rsp_keep && fifo_full && !id_fire));
         assert (!(imem_rsp_valid && (inflight == '0)));
         assert (!(req_fire && tag_full));
         assert (!(rsp_keep && tag_empty));
         assert (tag_count == inflight - drop);
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order, variable-latency memory model.
module tb_if_stage;

   localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b1;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   int unsigned passed = 0;
   int unsigned total  = 0;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } pend_t;

   pend_t       pend_q[$];
   logic [63:0] got[$];
   int unsigned cyc = 0;
   int unsigned mem_lat = 1;
   int unsigned req_count = 0;

   typedef struct {
      int unsigned lat;
      int unsigned pre;
      logic [31:0] tgt;
      logic [31:0] exp0;
      logic [31:0] exp1;
   } redir_vec_t;

   redir_vec_t vecs[5];

   if_stage #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: record accepts before the edge, answer in order after mem_lat edges
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst && imem_req_valid && imem_req_ready) begin
            pend_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
            req_count++;
         end
         @(posedge clk);
         #1;
         if (rst) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
         end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_q[0].addr ^ XOR_KEY;
            void'(pend_q.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
         end
      end
   end

   // Decode side: log every accepted instruction
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && id_valid && id_ready) got.push_back({id_pc, id_instr});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_item(input string name, input int unsigned idx, input logic [31:0] exp_pc);
      logic [63:0] it;
      if (idx >= got.size()) begin
         total++;
         $display("FAIL %s: only %0d items delivered, need item %0d", name, got.size(), idx);
      end else begin
         it = got[idx];
         check({name, "_pc"}, it[63:32], exp_pc);
         check({name, "_instr"}, it[31:0], exp_pc ^ XOR_KEY);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_items(input int unsigned n, input string name);
      int unsigned k = 0;
      while (got.size() < n && k < 200) begin
         @(posedge clk);
         k++;
      end
      #2;
      if (got.size() < n) begin
         total++;
         $display("FAIL %s: timeout with %0d items, need %0d", name, got.size(), n);
      end
   endtask

   // Leaves the bench 2ns into cycle 0 after reset release (FSM in S_BOOT)
   task automatic do_reset(input int unsigned lat, input logic idr);
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      id_ready       = idr;
      mem_lat        = lat;
      step();
      step();
      rst       = 1'b0;
      req_count = 0;
      got.delete();
   endtask

   initial begin
      int unsigned bad;
      int unsigned k;

      vecs[0] = '{lat: 1, pre: 6,  tgt: 32'h0000_0040, exp0: 32'h0000_0040, exp1: 32'h0000_0044};
      vecs[1] = '{lat: 3, pre: 8,  tgt: 32'h0000_0203, exp0: 32'h0000_0200, exp1: 32'h0000_0204};
      vecs[2] = '{lat: 2, pre: 5,  tgt: 32'hFFFF_FFFE, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000};
      vecs[3] = '{lat: 5, pre: 3,  tgt: 32'h0000_0007, exp0: 32'h0000_0004, exp1: 32'h0000_0008};
      vecs[4] = '{lat: 4, pre: 12, tgt: 32'h0000_1000, exp0: 32'h0000_1000, exp1: 32'h0000_1004};

      // Reset values while rst is held
      @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_id_valid",  {31'b0, id_valid},       32'd0);
      check("rst_id_instr",  id_instr,                NOP);
      check("rst_id_pc",     id_pc,                   32'd0);

      // Zero-wait streaming: boot cycle, first request, first id_valid in cycle 3
      do_reset(1, 1'b1);
      @(negedge clk);
      check("boot_no_req", {31'b0, imem_req_valid}, 32'd0);
      step();
      @(negedge clk);
      check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("first_req_addr",  imem_req_addr,           32'd0);
      step();
      @(negedge clk);
      check("cycle2_id_valid", {31'b0, id_valid}, 32'd0);
      step();
      @(negedge clk);
      check("cycle3_id_valid", {31'b0, id_valid}, 32'd1);
      check("cycle3_id_pc",    id_pc,             32'd0);
      wait_items(4, "stream");
      for (int unsigned i = 0; i < 4; i++) check_item("stream", i, 32'(4 * i));

      // Decode stalled: credit caps outstanding at 4, head stays stable
      do_reset(1, 1'b0);
      bad = 0;
      for (int unsigned i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i >= 3 && !(id_valid && id_pc == 32'd0)) bad++;
         step();
      end
      check("stall_req_count",  req_count,              32'd4);
      check("stall_head_bad",   bad,                    32'd0);
      check("stall_no_req",     {31'b0, imem_req_valid}, 32'd0);
      id_ready = 1'b1;
      wait_items(5, "release");
      for (int unsigned i = 0; i < 5; i++) check_item("release", i, 32'(4 * i));

      // Redirect table: varied latency and timing, same-cycle response dropped
      foreach (vecs[v]) begin
         do_reset(vecs[v].lat, 1'b1);
         for (int unsigned i = 0; i < vecs[v].pre; i++) step();
         redirect_valid = 1'b1;
         redirect_pc    = vecs[v].tgt;
         got.delete();
         @(negedge clk);
         check("redir_id_valid",  {31'b0, id_valid},       32'd0);
         check("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
         step();
         redirect_valid = 1'b0;
         @(negedge clk);
         check("redir_addr", imem_req_addr, vecs[v].exp0);
         wait_items(2, "redir");
         check_item("redir0", 0, vecs[v].exp0);
         check_item("redir1", 1, vecs[v].exp1);
      end

      // Redirect with exactly three requests in flight
      do_reset(8, 1'b1);
      k = 0;
      while (req_count < 3 && k < 20) begin
         step();
         k++;
      end
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      got.delete();
      @(negedge clk);
      check("inflight3_count", req_count, 32'd3);
      step();
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      wait_items(2, "inflight3");
      check_item("inflight3_a", 0, 32'h0000_0100);
      check_item("inflight3_b", 1, 32'h0000_0104);

      // Back-to-back redirects: the later target wins
      do_reset(2, 1'b1);
      for (int unsigned i = 0; i < 6; i++) step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      step();
      redirect_pc    = 32'h0000_0500;
      got.delete();
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("b2b_addr", imem_req_addr, 32'h0000_0500);
      wait_items(2, "b2b");
      check_item("b2b_a", 0, 32'h0000_0500);
      check_item("b2b_b", 1, 32'h0000_0504);

      // Reset mid-stream with two requests outstanding
      do_reset(3, 1'b1);
      k = 0;
      while (req_count < 2 && k < 20) begin
         step();
         k++;
      end
      rst = 1'b1;
      step();
      @(negedge clk);
      check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("midrst_id_valid",  {31'b0, id_valid},       32'd0);
      check("midrst_id_instr",  id_instr,                NOP);
      check("midrst_id_pc",     id_pc,                   32'd0);
      rst = 1'b0;
      got.delete();
      wait_items(2, "restart");
      check_item("restart_a", 0, 32'h0000_0000);
      check_item("restart_b", 1, 32'h0000_0004);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
